// File: rtl/input_action_decoder.sv
// Input action decoder: turns raw HID keycodes into frame-aligned, debounced game actions.
// Frame boundaries are the synchronized falling edges of the VGA vertical sync.
module input_action_decoder #(
   parameter int unsigned DEBOUNCE_FRAMES = 2,
   parameter int unsigned FIRE_COOLDOWN   = 8,
   parameter logic [7:0]  KEY_LEFT        = 8'h04,
   parameter logic [7:0]  KEY_RIGHT       = 8'h07,
   parameter logic [7:0]  KEY_UP          = 8'h1A,
   parameter logic [7:0]  KEY_DOWN        = 8'h16,
   parameter logic [7:0]  KEY_JUMP        = 8'h2C,
   parameter logic [7:0]  KEY_FIRE        = 8'h0E,
   parameter logic [7:0]  KEY_START       = 8'h28
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic [7:0] keycode_i,
   input  logic       vs_i,
   output logic       frame_tick_o,
   output logic       act_left_o,
   output logic       act_right_o,
   output logic       act_up_o,
   output logic       act_down_o,
   output logic       act_jump_o,
   output logic       act_start_o,
   output logic       fire_req_o,
   output logic [7:0] accepted_key_o
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StFire = 2'd1;
   localparam logic [1:0] StCool = 2'd2;

   localparam logic [3:0] DebMax     = 4'(DEBOUNCE_FRAMES);
   localparam logic [5:0] CoolReload = 6'(FIRE_COOLDOWN - 1);

   logic       vs_meta_q, vs_sync_q, vs_prev_q, tick_q;
   logic [7:0] key_q;
   logic [7:0] cand_q, cand_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] acc_q, acc_d;
   logic [5:0] act_q, act_d;
   logic       fire_q, fire_d;
   logic [1:0] state_q, state_d;
   logic [5:0] cool_q, cool_d, cool_dec;
   logic       fire_held;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         vs_meta_q <= 1'b1;
         vs_sync_q <= 1'b1;
         vs_prev_q <= 1'b1;
         tick_q    <= 1'b0;
         key_q     <= 8'h00;
         cand_q    <= 8'h00;
         cnt_q     <= 4'd0;
         acc_q     <= 8'h00;
         act_q     <= 6'd0;
         fire_q    <= 1'b0;
         state_q   <= StIdle;
         cool_q    <= 6'd0;
      end else begin
         vs_meta_q <= vs_i;
         vs_sync_q <= vs_meta_q;
         vs_prev_q <= vs_sync_q;
         tick_q    <= vs_prev_q & ~vs_sync_q;
         key_q     <= keycode_i;
         cand_q    <= cand_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         act_q     <= act_d;
         fire_q    <= fire_d;
         state_q   <= state_d;
         cool_q    <= cool_d;
      end
   end

   // All outputs are computed from next-state values so they change together,
   // exactly one Clk after frame_tick, and hold for the rest of the frame.
   always_comb begin
      cand_d    = cand_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      act_d     = act_q;
      fire_d    = fire_q;
      state_d   = state_q;
      cool_d    = cool_q;
      cool_dec  = cool_q - 6'd1;
      fire_held = 1'b0;
      if (tick_q) begin
         if (key_q != cand_q) begin
            cand_d = key_q;
            cnt_d  = 4'd1;
         end else if (cnt_q < DebMax) begin
            cnt_d = cnt_q + 4'd1;
         end
         if (cnt_d == DebMax) begin
            acc_d = cand_d;
         end
         act_d = {acc_d == KEY_LEFT,
                  acc_d == KEY_RIGHT,
                  acc_d == KEY_UP,
                  acc_d == KEY_DOWN,
                  (acc_d == KEY_JUMP) && (acc_q != KEY_JUMP),
                  (acc_d == KEY_START) && (acc_q != KEY_START)};
         fire_held = (acc_d == KEY_FIRE);
         fire_d    = 1'b0;
         case (state_q)
            StIdle: begin
               if (fire_held) begin
                  fire_d  = 1'b1;
                  cool_d  = CoolReload;
                  state_d = StFire;
               end
            end
            StFire: begin
               state_d = (cool_q == 6'd0) ? StIdle : StCool;
            end
            StCool: begin
               // Countdown runs to completion even if fire is released meanwhile.
               cool_d = cool_dec;
               if (cool_dec == 6'd0) begin
                  if (fire_held) begin
                     fire_d  = 1'b1;
                     cool_d  = CoolReload;
                     state_d = StFire;
                  end else begin
                     state_d = StIdle;
                  end
               end
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   assign frame_tick_o   = tick_q;
   assign accepted_key_o = acc_q;
   assign act_left_o     = act_q[5];
   assign act_right_o    = act_q[4];
   assign act_up_o       = act_q[3];
   assign act_down_o     = act_q[2];
   assign act_jump_o     = act_q[1];
   assign act_start_o    = act_q[0];
   assign fire_req_o     = fire_q;

endmodule

// File: tb/tb_input_action_decoder.sv
// Scoreboard bench for input_action_decoder: each frame pushes its hand-computed expected
// outputs; a monitor pops and compares in the Clk after every frame_tick.
module tb_input_action_decoder;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] keycode;
   logic       vs;
   logic       frame_tick;
   logic       act_left, act_right, act_up, act_down, act_jump, act_start, fire_req;
   logic [7:0] accepted_key;

   input_action_decoder dut (
      .clk_i          (clk),
      .reset_i        (reset),
      .keycode_i      (keycode),
      .vs_i           (vs),
      .frame_tick_o   (frame_tick),
      .act_left_o     (act_left),
      .act_right_o    (act_right),
      .act_up_o       (act_up),
      .act_down_o     (act_down),
      .act_jump_o     (act_jump),
      .act_start_o    (act_start),
      .fire_req_o     (fire_req),
      .accepted_key_o (accepted_key)
   );

   always #5 clk = ~clk;

   // {accepted_key, left, right, up, down, jump, start, fire}
   logic [14:0] dut_vec;
   assign dut_vec = {accepted_key, act_left, act_right, act_up, act_down,
                     act_jump, act_start, fire_req};

   logic [14:0] exp_q[$];
   int          n_vec = 0;
   int          n_bad = 0;
   bit          armed = 1'b0;
   bit          tick_seen = 1'b0;
   logic [14:0] last_vec = '0;
   logic [14:0] exp_v;

   // Monitor: compare after each tick, otherwise outputs must hold.
   always @(negedge clk) begin
      if (armed) begin
         if (tick_seen) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_tick: got %h, no expected entry", dut_vec);
            end else begin
               exp_v = exp_q.pop_front();
               if (dut_vec !== exp_v) begin
                  n_bad++;
                  $display("FAIL frame_outputs: got acc=%h act=%b, want acc=%h act=%b",
                           dut_vec[14:7], dut_vec[6:0], exp_v[14:7], exp_v[6:0]);
               end
            end
         end else if (!reset) begin
            n_vec++;
            if (dut_vec !== last_vec) begin
               n_bad++;
               $display("FAIL hold_between_ticks: got %h, want %h", dut_vec, last_vec);
            end
         end
      end
      tick_seen = frame_tick;
      last_vec  = dut_vec;
   end

   task automatic frame(input logic [7:0] key, input logic [7:0] acc, input logic [6:0] act,
                        input int reps, input int low);
      int lat;
      for (int r = 0; r < reps; r++) begin
         keycode = key;
         exp_q.push_back({acc, act});
         @(negedge clk);
         vs  = 1'b0;
         lat = 0;
         for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i >= low) vs = 1'b1;
            if (frame_tick && lat == 0) lat = i;
         end
         n_vec++;
         if (lat != 3) begin
            n_bad++;
            $display("FAIL tick_latency: got %0d Clk, want 3 (key %h)", lat, key);
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1);
   end

   initial begin
      reset   = 1'b1;
      keycode = 8'h04;
      vs      = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_vec++;
         if ({frame_tick, dut_vec} !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_state: got tick=%b vec=%h, want 0", frame_tick, dut_vec);
         end
         vs = ~vs;
      end
      vs = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      armed = 1'b1;

      // Debounce of left and its release.
      frame(8'h04, 8'h00, 7'b0000000, 1, 5);
      frame(8'h04, 8'h04, 7'b1000000, 2, 5);
      frame(8'h00, 8'h04, 7'b1000000, 1, 5);
      frame(8'h00, 8'h00, 7'b0000000, 1, 5);
      // Glitching right key with 1-Clk vsync pulses.
      frame(8'h07, 8'h00, 7'b0000000, 1, 1);
      frame(8'h00, 8'h00, 7'b0000000, 1, 1);
      frame(8'h07, 8'h00, 7'b0000000, 1, 1);
      frame(8'h00, 8'h00, 7'b0000000, 1, 1);
      // Jump: single pulse while held, another after release and re-press.
      frame(8'h2C, 8'h00, 7'b0000000, 1, 5);
      frame(8'h2C, 8'h2C, 7'b0000100, 1, 5);
      frame(8'h2C, 8'h2C, 7'b0000000, 2, 5);
      frame(8'h00, 8'h2C, 7'b0000000, 1, 5);
      frame(8'h00, 8'h00, 7'b0000000, 1, 5);
      frame(8'h2C, 8'h00, 7'b0000000, 1, 5);
      frame(8'h2C, 8'h2C, 7'b0000100, 1, 5);
      frame(8'h2C, 8'h2C, 7'b0000000, 1, 5);
      // Start pulse, then up and down levels.
      frame(8'h28, 8'h2C, 7'b0000000, 1, 5);
      frame(8'h28, 8'h28, 7'b0000010, 1, 5);
      frame(8'h28, 8'h28, 7'b0000000, 1, 5);
      frame(8'h1A, 8'h28, 7'b0000000, 1, 5);
      frame(8'h1A, 8'h1A, 7'b0010000, 1, 5);
      frame(8'h16, 8'h1A, 7'b0010000, 1, 5);
      frame(8'h16, 8'h16, 7'b0001000, 1, 5);
      // Fire held: requests at N, N+8, N+16.
      frame(8'h0E, 8'h16, 7'b0001000, 1, 5);
      frame(8'h0E, 8'h0E, 7'b0000001, 1, 5);
      frame(8'h0E, 8'h0E, 7'b0000000, 7, 5);
      frame(8'h0E, 8'h0E, 7'b0000001, 1, 5);
      frame(8'h0E, 8'h0E, 7'b0000000, 7, 5);
      frame(8'h0E, 8'h0E, 7'b0000001, 1, 5);
      // Release and quick re-press cannot beat the cooldown.
      frame(8'h0E, 8'h0E, 7'b0000000, 1, 5);
      frame(8'h00, 8'h0E, 7'b0000000, 1, 5);
      frame(8'h00, 8'h00, 7'b0000000, 1, 5);
      frame(8'h0E, 8'h00, 7'b0000000, 1, 5);
      frame(8'h0E, 8'h0E, 7'b0000000, 3, 5);
      frame(8'h0E, 8'h0E, 7'b0000001, 1, 5);
      frame(8'h0E, 8'h0E, 7'b0000000, 1, 5);
      // Release lets the countdown expire, then a fresh press fires at once.
      frame(8'h00, 8'h0E, 7'b0000000, 1, 5);
      frame(8'h00, 8'h00, 7'b0000000, 6, 5);
      frame(8'h0E, 8'h00, 7'b0000000, 1, 5);
      frame(8'h0E, 8'h0E, 7'b0000001, 1, 5);
      frame(8'h04, 8'h0E, 7'b0000000, 1, 5);
      frame(8'h04, 8'h04, 7'b1000000, 1, 5);

      // Mid-operation reset clears everything; left must debounce again.
      armed = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      #1;
      n_vec++;
      if ({frame_tick, dut_vec} !== 16'h0000) begin
         n_bad++;
         $display("FAIL mid_reset: got tick=%b vec=%h, want 0", frame_tick, dut_vec);
      end
      reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      armed = 1'b1;
      frame(8'h04, 8'h00, 7'b0000000, 1, 5);
      frame(8'h04, 8'h04, 7'b1000000, 1, 5);

      repeat (5) @(negedge clk);
      n_vec++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL missing_ticks: got %0d unconsumed entries, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
